// File: rtl/window_sad_matcher.sv
// window_sad_matcher: compares a stream of 16x16 byte windows against a stored
// 16x16 template. Each window takes one row of absolute differences per cycle.
// The matcher keeps the position of the lowest-SAD window in the current frame
// and reports it when the frame ends.
//
// Handshake: receive is asserted only in IDLE, only when window_ready is high,
// and only when no frame end (live or pending) is waiting. A window is accepted
// on exactly the clock edge where receive is high. window_ready is not looked
// at in any other state.
module window_sad_matcher #(
    parameter int WIN     = 16,
    parameter int POS_MAX = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tmpl_we,
    input  logic [5:0]           tmpl_addr,
    input  logic [31:0]          tmpl_data,
    input  logic [WIN*WIN*8-1:0] window_data,
    input  logic                 window_ready,
    output logic                 receive,
    input  logic                 frame_done,
    output logic                 busy,
    output logic                 result_valid,
    output logic [15:0]          best_sad,
    output logic [6:0]           best_row,
    output logic [6:0]           best_col
);

    localparam int RW = $clog2(WIN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_CMP    = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t               state_q;
    logic [7:0]           tmpl_q [WIN][WIN];
    logic [WIN*WIN*8-1:0] win_q;
    logic [RW-1:0]        row_cnt_q;
    logic [15:0]          acc_q;
    logic [15:0]          acc_d;
    logic [15:0]          row_sad;
    logic [WIN*8-1:0]     win_row;
    logic [7:0]           win_byte;
    logic [7:0]           tmpl_byte;
    logic [7:0]           abs_diff;
    logic [15:0]          best_sad_q;
    logic [6:0]           best_row_q;
    logic [6:0]           best_col_q;
    logic [6:0]           pos_row_q;
    logic [6:0]           pos_col_q;
    logic [6:0]           pos_row_d;
    logic [6:0]           pos_col_d;
    logic                 pend_q;
    logic                 busy_q;
    logic                 result_valid_q;
    logic [15:0]          best_sad_out_q;
    logic [6:0]           best_row_out_q;
    logic [6:0]           best_col_out_q;

    // Accept is a same-cycle decode of the handshake, so it is not registered.
    assign receive      = !rst && (state_q == S_IDLE) && window_ready && !frame_done && !pend_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign best_sad     = best_sad_out_q;
    assign best_row     = best_row_out_q;
    assign best_col     = best_col_out_q;

    // Template store: one 4-byte word per write, bits[31:24] land in the lowest column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    tmpl_q[r][c] <= '0;
                end
            end
        end else if (tmpl_we) begin
            for (int k = 0; k < 4; k++) begin
                tmpl_q[tmpl_addr[5:2]][{tmpl_addr[1:0], 2'(k)}] <= tmpl_data[31-8*k -: 8];
            end
        end
    end

    // Sum of absolute byte differences for the row selected by the row counter.
    always_comb begin
        win_row   = win_q[row_cnt_q*(WIN*8) +: WIN*8];
        row_sad   = '0;
        win_byte  = '0;
        tmpl_byte = '0;
        abs_diff  = '0;
        for (int c = 0; c < WIN; c++) begin
            win_byte  = win_row[c*8 +: 8];
            tmpl_byte = tmpl_q[row_cnt_q][c];
            abs_diff  = (win_byte >= tmpl_byte) ? (win_byte - tmpl_byte) : (tmpl_byte - win_byte);
            row_sad   = row_sad + {8'd0, abs_diff};
        end
        acc_d = acc_q + row_sad;
    end

    // Raster advance of the window position, wrapping both axes at POS_MAX.
    always_comb begin
        pos_row_d = pos_row_q;
        pos_col_d = pos_col_q + 7'd1;
        if (pos_col_q == 7'(POS_MAX)) begin
            pos_col_d = '0;
            pos_row_d = (pos_row_q == 7'(POS_MAX)) ? 7'd0 : (pos_row_q + 7'd1);
        end
    end

    // Control FSM: accept, accumulate 16 rows, compare, report at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            win_q          <= '0;
            row_cnt_q      <= '0;
            acc_q          <= '0;
            best_sad_q     <= 16'hFFFF;
            best_row_q     <= '0;
            best_col_q     <= '0;
            pos_row_q      <= '0;
            pos_col_q      <= '0;
            pend_q         <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            best_sad_out_q <= 16'hFFFF;
            best_row_out_q <= '0;
            best_col_out_q <= '0;
        end else begin
            result_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (frame_done || pend_q) begin
                        // Frame end wins over a waiting window.
                        best_sad_out_q <= best_sad_q;
                        best_row_out_q <= best_row_q;
                        best_col_out_q <= best_col_q;
                        result_valid_q <= 1'b1;
                        state_q        <= S_REPORT;
                    end else if (window_ready) begin
                        win_q     <= window_data;
                        acc_q     <= '0;
                        row_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_q     <= acc_d;
                    row_cnt_q <= row_cnt_q + RW'(1);
                    if (frame_done) begin
                        pend_q <= 1'b1;
                    end
                    if (row_cnt_q == RW'(WIN - 1)) begin
                        state_q <= S_CMP;
                    end
                end
                S_CMP: begin
                    // Strict less-than: on a tie the earlier window is kept.
                    if (acc_q < best_sad_q) begin
                        best_sad_q <= acc_q;
                        best_row_q <= pos_row_q;
                        best_col_q <= pos_col_q;
                    end
                    pos_row_q <= pos_row_d;
                    pos_col_q <= pos_col_d;
                    if (frame_done) begin
                        pend_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_REPORT: begin
                    best_sad_q <= 16'hFFFF;
                    best_row_q <= '0;
                    best_col_q <= '0;
                    pos_row_q  <= '0;
                    pos_col_q  <= '0;
                    pend_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_sad_matcher.sv
// Bench for window_sad_matcher: directed and randomized frames. The results are
// compared against a frame-level reference model that computes whole-window SADs.
module tb_window_sad_matcher;

    localparam int WIN     = 16;
    localparam int POS_MAX = 64;
    localparam int NPOS    = POS_MAX + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            tmpl_we;
    logic [5:0]      tmpl_addr;
    logic [31:0]     tmpl_data;
    logic [2047:0]   window_data;
    logic            window_ready;
    logic            receive;
    logic            frame_done;
    logic            busy;
    logic            result_valid;
    logic [15:0]     best_sad;
    logic [6:0]      best_row;
    logic [6:0]      best_col;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] tmpl_m [16][16];
    int m_best_sad;
    int m_best_row;
    int m_best_col;
    int m_count;

    window_sad_matcher #(.WIN(WIN), .POS_MAX(POS_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .tmpl_we      (tmpl_we),
        .tmpl_addr    (tmpl_addr),
        .tmpl_data    (tmpl_data),
        .window_data  (window_data),
        .window_ready (window_ready),
        .receive      (receive),
        .frame_done   (frame_done),
        .busy         (busy),
        .result_valid (result_valid),
        .best_sad     (best_sad),
        .best_row     (best_row),
        .best_col     (best_col)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int sad_of(input logic [2047:0] w);
        int s;
        s = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                int a;
                int b;
                a = int'(w[(r*16+c)*8 +: 8]);
                b = int'(tmpl_m[r][c]);
                s += (a > b) ? (a - b) : (b - a);
            end
        end
        return s;
    endfunction

    task automatic model_accept(input logic [2047:0] w);
        int s;
        int pos;
        s   = sad_of(w);
        pos = m_count % (NPOS * NPOS);
        if (s < m_best_sad) begin
            m_best_sad = s;
            m_best_row = pos / NPOS;
            m_best_col = pos % NPOS;
        end
        m_count++;
    endtask

    task automatic model_frame_reset();
        m_best_sad = 65535;
        m_best_row = 0;
        m_best_col = 0;
        m_count    = 0;
    endtask

    function automatic logic [2047:0] rand_window();
        logic [2047:0] w;
        for (int i = 0; i < 64; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [2047:0] fill_window(input logic [7:0] v);
        logic [2047:0] w;
        for (int i = 0; i < 256; i++) w[i*8 +: 8] = v;
        return w;
    endfunction

    function automatic logic [2047:0] tmpl_window();
        logic [2047:0] w;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) w[(r*16+c)*8 +: 8] = tmpl_m[r][c];
        return w;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_template_fill(input logic [7:0] v);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) tmpl_m[r][c] = v;
    endtask

    task automatic set_template_rand();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) tmpl_m[r][c] = 8'($urandom_range(0, 255));
    endtask

    task automatic load_template();
        for (int r = 0; r < 16; r++) begin
            for (int w = 0; w < 4; w++) begin
                tmpl_we   = 1'b1;
                tmpl_addr = 6'(r*4 + w);
                tmpl_data = {tmpl_m[r][4*w], tmpl_m[r][4*w+1], tmpl_m[r][4*w+2], tmpl_m[r][4*w+3]};
                tick();
            end
        end
        tmpl_we = 1'b0;
    endtask

    // Offer a window and wait (bounded) for the accept edge; returns in ACCUM row 0.
    task automatic send_window(input logic [2047:0] w);
        int n;
        window_data  = w;
        window_ready = 1'b1;
        #1;
        n = 0;
        while (receive !== 1'b1 && n < 60) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (receive !== 1'b1) begin
            errors++;
            $display("FAIL send_window accept: receive=%b required 1 within 60 cycles", receive);
        end else begin
            model_accept(w);
        end
        tick();
        window_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b required 0 within 40 cycles", busy);
        end
    endtask

    task automatic pulse_frame_done();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    // Wait for result_valid; n = cycles waited (-1 on timeout), ok = one-cycle pulse with held outputs.
    task automatic wait_result(output int n, output logic [15:0] s, output logic [6:0] r,
                               output logic [6:0] c, output logic ok);
        n = 0;
        while (result_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (result_valid !== 1'b1) begin
            n  = -1;
            s  = 'x;
            r  = 'x;
            c  = 'x;
            ok = 1'b0;
        end else begin
            s = best_sad;
            r = best_row;
            c = best_col;
            tick();
            ok = (result_valid === 1'b0) && (best_sad === s) && (best_row === r) && (best_col === c);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst          = 1'b1;
        tmpl_we      = 1'b0;
        tmpl_addr    = '0;
        tmpl_data    = '0;
        window_data  = '0;
        window_ready = 1'b1;
        frame_done   = 1'b0;
        model_frame_reset();
        set_template_fill(8'h00);
        tick();
        tick();
        checks++;
        if (receive !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: receive=%b busy=%b result_valid=%b required 0 0 0",
                     receive, busy, result_valid);
        end
        checks++;
        if (best_sad !== 16'hFFFF || best_row !== 7'd0 || best_col !== 7'd0) begin
            errors++;
            $display("FAIL reset_best: sad=%h row=%0d col=%0d required ffff 0 0", best_sad, best_row, best_col);
        end
        window_ready = 1'b0;
        rst          = 1'b0;
        tick();
    endtask

    task automatic test_zero_sad();
        int bcnt;
        int rcnt;
        int n;
        logic [15:0] s;
        logic [6:0] r, c;
        logic ok;
        set_template_fill(8'h10);
        load_template();
        window_data  = fill_window(8'h10);
        window_ready = 1'b1;
        #1;
        checks++;
        if (receive !== 1'b1) begin
            errors++;
            $display("FAIL zero_sad_accept: receive=%b required 1", receive);
        end
        model_accept(window_data);
        tick();
        window_ready = 1'b0;
        bcnt = 0;
        rcnt = 0;
        for (int i = 0; i < 25; i++) begin
            #1;
            if (busy === 1'b1) bcnt++;
            if (receive === 1'b1) rcnt++;
            tick();
        end
        checks++;
        if (bcnt !== 17 || rcnt !== 0) begin
            errors++;
            $display("FAIL zero_sad_busy: busy cycles=%0d extra receive=%0d required 17 0", bcnt, rcnt);
        end
        pulse_frame_done();
        wait_result(n, s, r, c, ok);
        checks++;
        if (s !== 16'd0 || r !== 7'd0 || c !== 7'd0 || s !== 16'(m_best_sad) || !ok) begin
            errors++;
            $display("FAIL zero_sad_result: sad=%0d row=%0d col=%0d pulse_ok=%b required 0 0 0 1", s, r, c, ok);
        end
        model_frame_reset();
    endtask

    task automatic test_max_sad();
        int n;
        logic [15:0] s;
        logic [6:0] r, c;
        logic ok;
        set_template_fill(8'h00);
        load_template();
        send_window(fill_window(8'hFF));
        wait_idle();
        pulse_frame_done();
        wait_result(n, s, r, c, ok);
        checks++;
        if (s !== 16'd65280 || s !== 16'(m_best_sad) || r !== 7'd0 || c !== 7'd0 || !ok) begin
            errors++;
            $display("FAIL max_sad: sad=%0d row=%0d col=%0d required 65280 0 0", s, r, c);
        end
        model_frame_reset();
    endtask

    task automatic test_tie();
        logic [2047:0] w;
        int n;
        logic [15:0] s;
        logic [6:0] r, c;
        logic ok;
        // Template still zero: SAD is just the byte sum.
        w = '0; w[7:0] = 8'd255; w[15:8] = 8'd245;
        send_window(w);
        wait_idle();
        w = '0; w[7:0] = 8'd200;
        send_window(w);
        wait_idle();
        w = '0; w[47:40] = 8'd200;
        send_window(w);
        wait_idle();
        pulse_frame_done();
        wait_result(n, s, r, c, ok);
        checks++;
        if (s !== 16'd200 || r !== 7'd0 || c !== 7'd1 || !ok) begin
            errors++;
            $display("FAIL tie_keeps_first: sad=%0d row=%0d col=%0d required 200 0 1", s, r, c);
        end
        model_frame_reset();
    endtask

    task automatic test_empty_frame();
        int n;
        logic [15:0] s;
        logic [6:0] r, c;
        logic ok;
        pulse_frame_done();
        wait_result(n, s, r, c, ok);
        checks++;
        if (s !== 16'hFFFF || r !== 7'd0 || c !== 7'd0 || !ok) begin
            errors++;
            $display("FAIL empty_frame: sad=%h row=%0d col=%0d required ffff 0 0", s, r, c);
        end
        model_frame_reset();
    endtask

    task automatic test_done_priority();
        int n;
        logic [15:0] s;
        logic [6:0] r, c;
        logic ok;
        window_data  = rand_window();
        window_ready = 1'b1;
        frame_done   = 1'b1;
        #1;
        checks++;
        if (receive !== 1'b0) begin
            errors++;
            $display("FAIL done_priority_receive: receive=%b required 0", receive);
        end
        tick();
        frame_done   = 1'b0;
        window_ready = 1'b0;
        wait_result(n, s, r, c, ok);
        checks++;
        if (n !== 0 || s !== 16'hFFFF || r !== 7'd0 || c !== 7'd0 || !ok) begin
            errors++;
            $display("FAIL done_priority_result: wait=%0d sad=%h row=%0d col=%0d required 0 ffff 0 0", n, s, r, c);
        end
        model_frame_reset();
    endtask

    task automatic test_random_frames();
        int n;
        int nwin;
        logic [15:0] s;
        logic [6:0] r, c;
        logic ok;
        for (int f = 0; f < 3; f++) begin
            set_template_rand();
            load_template();
            nwin = $urandom_range(2, 6);
            for (int i = 0; i < nwin; i++) begin
                if ($urandom_range(0, 3) == 0) send_window(tmpl_window() ^ 2048'($urandom_range(0, 255)));
                else send_window(rand_window());
                wait_idle();
            end
            pulse_frame_done();
            wait_result(n, s, r, c, ok);
            checks++;
            if (s !== 16'(m_best_sad) || r !== 7'(m_best_row) || c !== 7'(m_best_col) || !ok) begin
                errors++;
                $display("FAIL random_frame%0d: sad=%0d row=%0d col=%0d required %0d %0d %0d",
                         f, s, r, c, m_best_sad, m_best_row, m_best_col);
            end
            model_frame_reset();
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int last;
        int accepted;
        int overlap;
        int n;
        logic [15:0] s;
        logic [6:0] r, c;
        logic ok;
        set_template_rand();
        load_template();
        window_data  = rand_window();
        window_ready = 1'b1;
        cyc      = 0;
        last     = -1;
        accepted = 0;
        overlap  = 0;
        while (accepted < 66 && cyc < 66*18 + 50) begin
            #1;
            if (receive === 1'b1 && busy === 1'b1) overlap++;
            if (receive === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 18) begin
                        errors++;
                        $display("FAIL b2b_interval: accept %0d gap=%0d required 18", accepted, cyc - last);
                    end
                end
                model_accept(window_data);
                last = cyc;
                accepted++;
                tick();
                // The 66th window is an exact template copy so it must win.
                window_data = (accepted == 65) ? tmpl_window() : rand_window();
            end else begin
                tick();
            end
            cyc++;
        end
        window_ready = 1'b0;
        checks++;
        if (accepted !== 66 || overlap !== 0) begin
            errors++;
            $display("FAIL b2b_accepts: accepted=%0d receive_while_busy=%0d required 66 0", accepted, overlap);
        end
        wait_idle();
        pulse_frame_done();
        wait_result(n, s, r, c, ok);
        checks++;
        if (s !== 16'(m_best_sad) || r !== 7'd1 || c !== 7'd0 || s !== 16'd0 || !ok) begin
            errors++;
            $display("FAIL b2b_result: sad=%0d row=%0d col=%0d required 0 1 0", s, r, c);
        end
        model_frame_reset();
    endtask

    task automatic test_pending_done();
        int n;
        logic [15:0] s;
        logic [6:0] r, c;
        logic ok;
        send_window(tmpl_window());
        // Now in ACCUM cycle 1; step to ACCUM cycle 5.
        for (int i = 0; i < 4; i++) tick();
        pulse_frame_done();
        wait_result(n, s, r, c, ok);
        // Rows still to go after cycle 5 (11), then CMP, IDLE, REPORT: 13 cycles after the pulse ends.
        checks++;
        if (n !== 13) begin
            errors++;
            $display("FAIL pending_latency: cycles=%0d required 13", n);
        end
        checks++;
        if (s !== 16'd0 || r !== 7'd0 || c !== 7'd0 || !ok) begin
            errors++;
            $display("FAIL pending_result: sad=%0d row=%0d col=%0d required 0 0 0", s, r, c);
        end
        model_frame_reset();
        // Next frame must start over: a worse window is still reported at 0/0.
        send_window(rand_window());
        wait_idle();
        pulse_frame_done();
        wait_result(n, s, r, c, ok);
        checks++;
        if (s !== 16'(m_best_sad) || r !== 7'd0 || c !== 7'd0 || !ok) begin
            errors++;
            $display("FAIL pending_next_frame: sad=%0d row=%0d col=%0d required %0d 0 0", s, r, c, m_best_sad);
        end
        model_frame_reset();
    endtask

    task automatic test_reset_mid_accum();
        int rv;
        int n;
        logic [2047:0] w;
        logic [15:0] s;
        logic [6:0] r, c;
        logic ok;
        send_window(rand_window());
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || receive !== 1'b0 ||
            best_sad !== 16'hFFFF || best_row !== 7'd0 || best_col !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b rv=%b receive=%b sad=%h row=%0d col=%0d required 0 0 0 ffff 0 0",
                     busy, result_valid, receive, best_sad, best_row, best_col);
        end
        tick();
        tick();
        rst = 1'b0;
        set_template_fill(8'h00);
        model_frame_reset();
        rv = 0;
        for (int i = 0; i < 20; i++) begin
            if (result_valid === 1'b1) rv++;
            tick();
        end
        checks++;
        if (rv !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_result: result_valid cycles=%0d required 0", rv);
        end
        // Small bytes first, full-range second: the first window (0/0) is best against the cleared template.
        for (int i = 0; i < 256; i++) w[i*8 +: 8] = 8'($urandom_range(0, 3));
        send_window(w);
        wait_idle();
        send_window(rand_window());
        wait_idle();
        pulse_frame_done();
        wait_result(n, s, r, c, ok);
        checks++;
        if (s !== 16'(m_best_sad) || r !== 7'd0 || c !== 7'd0 || !ok) begin
            errors++;
            $display("FAIL reset_mid_next: sad=%0d row=%0d col=%0d required %0d 0 0", s, r, c, m_best_sad);
        end
        model_frame_reset();
    endtask

    initial begin
        test_reset();
        test_zero_sad();
        test_max_sad();
        test_tie();
        test_empty_frame();
        test_done_priority();
        test_random_frames();
        test_back_to_back();
        test_pending_done();
        test_reset_mid_accum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
